fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage plus IF/ID pipeline register of the MIPS pipeline; directly upstream of Control.
//   Owns the PC, drives the instruction-memory address and registers the fetched word.
//   Slices the word into op/Funct (fed straight to Control) and the rs/rt/rd/shamt/imm/target fields.
//   Honours hazard stalls, branch/jump redirects and a syscall-driven halt.
// PARAMETERS
//   RESET_PC   32'h0000_3000  PC value loaded on reset
//   IMEM_AW    10             instruction-memory word-address width
// PORTS
//   clk           in   1        single clock, rising edge
//   rst           in   1        asynchronous, active-high reset
//   imem_addr     out  IMEM_AW  word address = pc[IMEM_AW+1:2]
//   imem_rdata    in   32       instruction word (combinational read of imem_addr)
//   imem_ready    in   1        1 = imem_rdata is valid this cycle
//   stall         in   1        load-use/hazard stall from hazard unit
//   redirect      in   1        taken branch / j / jal / jr resolved in ID
//   redirect_pc   in   32       redirect target
//   halt_req      in   1        syscall exit decoded in ID
//   pc_out        out  32       current fetch PC
//   id_valid      out  1        IF/ID slot holds a real instruction
//   id_instr      out  32       registered instruction (0 = NOP/bubble)
//   id_pc4        out  32       PC+4 of id_instr (jal link value)
//   id_op, id_funct  out 6      instr[31:26], instr[5:0] -> Control.op / Control.Funct
//   id_rs, id_rt, id_rd, id_shamt  out 5  instr[25:21], [20:16], [15:11], [10:6]
//   id_imm16      out  16       instr[15:0]
//   id_target     out  26       instr[25:0]
//   halted        out  1        core is halted
//   perf_fetch, perf_stall, perf_flush  out 32  perf counters (see CONFIGURATION)
// BEHAVIOUR
//   Reset (async): pc=RESET_PC; id_valid=0; id_instr=0; id_pc4=0; halted=0; state=RUN; counters=0.
//   FSM: RUN -> HALT on halt_req (in RUN); HALT is exited only by rst.
//   Per-edge priority in RUN: halt_req > redirect > stall > !imem_ready > normal.
//     normal:      pc<=pc+4; id_instr<=imem_rdata; id_pc4<=pc+4; id_valid<=1.
//     !imem_ready: pc holds; IF/ID loads bubble (id_valid=0, id_instr=0).
//     stall:       pc and whole IF/ID hold unchanged; imem_ready ignored.
//     redirect:    pc<={redirect_pc[31:2],2'b00}; IF/ID loads bubble. No delay slot.
//                  Redirect overrides a simultaneous stall.
//     halt_req:    pc holds; IF/ID loads bubble; halted<=1 on the same edge.
//   In HALT: pc frozen; IF/ID bubble every cycle; stall/redirect/halt_req/imem_ready ignored.
//   Latency: imem_rdata at fetch PC P appears on id_instr one edge later, with id_pc4=P+4.
//   Arithmetic: pc+4 is modulo 2^32 (32'hFFFF_FFFC -> 0). pc[1:0] is always 00.
//   Field outputs are pure slices of id_instr; a bubble decodes as sll $0,$0,0 (op=0, funct=0).
//   Reset asserted mid-stall or mid-redirect: all state returns to reset values immediately.
// CONFIGURATION
//   FETCH_PERF_CNT_EN defined:
//     perf_fetch +1 per edge loading a valid instruction.
//     perf_stall +1 per edge with stall=1 and no redirect, in RUN.
//     perf_flush +1 per redirect edge, in RUN.
//     All counters wrap at 2^32 and clear on rst.
//   Not defined: the three perf ports remain and are tied to 32'h0; no counter flops are built.
// STRUCTURE
//   mips_pkg: opcode/funct localparams (J=6'h02, JAL=6'h03, SPECIAL=6'h00, JR=6'h08,
//     SYSCALL=6'h0C), NOP word 32'h0, fetch FSM state encodings.
//   Sub-module if_id_reg: 32+32+1 bit register with hold (stall) and flush (bubble) controls.
//   fetch_stage holds the PC, FSM, next-PC mux and counters.
// TESTING
//   1 Reset: rst=1 -> pc_out=32'h3000, id_valid=0, id_instr=0, halted=0; release -> next edge pc=32'h3004.
//   2 Streaming: ROM[0..2]=add,lw,sw, imem_ready=1 -> id_instr follows one edge behind pc;
//     id_op/id_funct drive Control (add: op=0, funct=6'h20).
//   3 Stall: stall=1 for 2 cycles holding lw -> pc and id_instr unchanged for 2 cycles; resumes at next word.
//   4 Redirect+stall same edge, redirect_pc=32'h3041 -> pc=32'h3040, id_valid=0, perf_flush=1 (macro on).
//   5 imem_ready=0 for 3 cycles -> pc holds; 3 bubbles with id_instr=0; then fetch resumes.
//   6 halt_req=1 with redirect=1 -> halted=1, pc frozen, bubbles only; stall/redirect ignored until rst.
//     Also pc=32'hFFFF_FFFC wraps to 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct codes, the NOP word
// and the fetch FSM state encoding.
package mips_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;

    // sll $0,$0,0 -- the bubble word
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid bit.
// Ports: clk, rst (async, active-high); hold keeps contents;
//   flush loads a bubble (wins over hold); otherwise instr_in/pc4_in
//   load with valid=1. Outputs valid, instr, pc4.
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        flush,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc4_in,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc4
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= NOP_WORD;
            pc4   <= 32'h0;
        end else if (flush) begin
            valid <= 1'b0;
            instr <= NOP_WORD;
            pc4   <= 32'h0;
        end else if (!hold) begin
            valid <= 1'b1;
            instr <= instr_in;
            pc4   <= pc4_in;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, run/halt FSM, next-PC mux, IF/ID
// register and field slicing. Ports: clk, rst (async, active-high);
// imem_addr/imem_rdata/imem_ready to instruction memory; stall,
// redirect/redirect_pc, halt_req from ID/hazard; pc_out, id_* IF/ID
// contents and fields; halted; perf_fetch/perf_stall/perf_flush.
// Optional counters built only with FETCH_PERF_CNT_EN defined;
// otherwise the perf ports read 32'h0.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          IMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               rst,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               imem_ready,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    input  logic               halt_req,
    output logic [31:0]        pc_out,
    output logic               id_valid,
    output logic [31:0]        id_instr,
    output logic [31:0]        id_pc4,
    output logic [5:0]         id_op,
    output logic [5:0]         id_funct,
    output logic [4:0]         id_rs,
    output logic [4:0]         id_rt,
    output logic [4:0]         id_rd,
    output logic [4:0]         id_shamt,
    output logic [15:0]        id_imm16,
    output logic [25:0]        id_target,
    output logic               halted,
    output logic [31:0]        perf_fetch,
    output logic [31:0]        perf_stall,
    output logic [31:0]        perf_flush
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt, pc_plus4, redir_aligned;
    logic         hold, flush, load;

    assign pc_plus4      = pc + 32'd4;
    assign redir_aligned = redirect_pc & ~32'h3;
    assign imem_addr     = pc[IMEM_AW+1:2];
    assign pc_out        = pc;
    assign halted        = (state == FS_HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FS_RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        hold      = 1'b0;
        flush     = 1'b0;
        load      = 1'b0;
        case (state)
            FS_RUN: begin
                if (halt_req) begin
                    state_nxt = FS_HALT;
                    flush     = 1'b1;
                end else if (redirect) begin
                    // No delay slot: the word fetched now is dropped.
                    pc_nxt = redir_aligned;
                    flush  = 1'b1;
                end else if (stall) begin
                    hold = 1'b1;
                end else if (!imem_ready) begin
                    flush = 1'b1;
                end else begin
                    pc_nxt = pc_plus4;
                    load   = 1'b1;
                end
            end
            FS_HALT: begin
                flush = 1'b1;
            end
            default: begin
                state_nxt = FS_RUN;
            end
        endcase
    end

    if_id_reg u_if_id (
        .clk      (clk),
        .rst      (rst),
        .hold     (hold),
        .flush    (flush),
        .instr_in (imem_rdata),
        .pc4_in   (pc_plus4),
        .valid    (id_valid),
        .instr    (id_instr),
        .pc4      (id_pc4)
    );

    assign id_op     = id_instr[31:26];
    assign id_rs     = id_instr[25:21];
    assign id_rt     = id_instr[20:16];
    assign id_rd     = id_instr[15:11];
    assign id_shamt  = id_instr[10:6];
    assign id_funct  = id_instr[5:0];
    assign id_imm16  = id_instr[15:0];
    assign id_target = id_instr[25:0];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] cnt_fetch, cnt_stall, cnt_flush;
    logic        in_run;

    assign in_run = (state == FS_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_fetch <= 32'h0;
            cnt_stall <= 32'h0;
            cnt_flush <= 32'h0;
        end else begin
            if (load)
                cnt_fetch <= cnt_fetch + 32'd1;
            if (in_run && stall && !redirect)
                cnt_stall <= cnt_stall + 32'd1;
            if (in_run && redirect)
                cnt_flush <= cnt_flush + 32'd1;
        end
    end

    assign perf_fetch = cnt_fetch;
    assign perf_stall = cnt_stall;
    assign perf_flush = cnt_flush;
`else
    assign perf_fetch = 32'h0;
    assign perf_stall = 32'h0;
    assign perf_flush = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a reference model predicts each
// edge, expectations are queued and compared after the edge.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic [31:0] pc_out;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic [5:0]  id_op, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [15:0] id_imm16;
    logic [25:0] id_target;
    logic        halted;
    logic [31:0] perf_fetch, perf_stall, perf_flush;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt_req    (halt_req),
        .pc_out      (pc_out),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc4      (id_pc4),
        .id_op       (id_op),
        .id_funct    (id_funct),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rd       (id_rd),
        .id_shamt    (id_shamt),
        .id_imm16    (id_imm16),
        .id_target   (id_target),
        .halted      (halted),
        .perf_fetch  (perf_fetch),
        .perf_stall  (perf_stall),
        .perf_flush  (perf_flush)
    );

    localparam logic [31:0] I_ADD = 32'h012A_4020;
    localparam logic [31:0] I_LW  = 32'h8D28_0004;
    localparam logic [31:0] I_SW  = 32'hAD28_0008;

    logic [31:0] rom [1024];

    assign imem_rdata = rom[imem_addr];

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        halted;
        logic [31:0] pf;
        logic [31:0] ps;
        logic [31:0] pfl;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int passed = 0;

    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr, m_pc4;
    logic        m_halt;
    logic [31:0] m_pf, m_ps, m_pfl;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pc    = 32'h0000_3000;
        m_valid = 1'b0;
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_halt  = 1'b0;
        m_pf    = 32'h0;
        m_ps    = 32'h0;
        m_pfl   = 32'h0;
    endtask

    // Predict one edge from the driven inputs, then queue it.
    task automatic predict();
        exp_t e;
        logic [31:0] w;
        logic        bub;
        w   = rom[m_pc[11:2]];
        bub = 1'b0;
        if (!m_halt) begin
            if (stall && !redirect) m_ps = m_ps + 1;
            if (redirect) m_pfl = m_pfl + 1;
        end
        if (m_halt) begin
            bub = 1'b1;
        end else if (halt_req) begin
            bub    = 1'b1;
            m_halt = 1'b1;
        end else if (redirect) begin
            bub  = 1'b1;
            m_pc = {redirect_pc[31:2], 2'b00};
        end else if (stall) begin
            bub = 1'b0;
        end else if (!imem_ready) begin
            bub = 1'b1;
        end else begin
            m_valid = 1'b1;
            m_instr = w;
            m_pc4   = m_pc + 32'd4;
            m_pc    = m_pc + 32'd4;
            m_pf    = m_pf + 1;
        end
        if (bub) begin
            m_valid = 1'b0;
            m_instr = 32'h0;
        end
        e.pc     = m_pc;
        e.valid  = m_valid;
        e.instr  = m_instr;
        e.pc4    = m_pc4;
        e.halted = m_halt;
`ifdef FETCH_PERF_CNT_EN
        e.pf  = m_pf;
        e.ps  = m_ps;
        e.pfl = m_pfl;
`else
        e.pf  = 32'h0;
        e.ps  = 32'h0;
        e.pfl = 32'h0;
`endif
        sb.push_back(e);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, ".pc"}, pc_out, e.pc);
        check({tag, ".valid"}, 32'(id_valid), 32'(e.valid));
        check({tag, ".instr"}, id_instr, e.instr);
        check({tag, ".halted"}, 32'(halted), 32'(e.halted));
        check({tag, ".perf_fetch"}, perf_fetch, e.pf);
        check({tag, ".perf_stall"}, perf_stall, e.ps);
        check({tag, ".perf_flush"}, perf_flush, e.pfl);
        if (e.valid) begin
            check({tag, ".pc4"}, id_pc4, e.pc4);
            check({tag, ".op"}, 32'(id_op), 32'(e.instr[31:26]));
            check({tag, ".funct"}, 32'(id_funct), 32'(e.instr[5:0]));
            check({tag, ".rs"}, 32'(id_rs), 32'(e.instr[25:21]));
            check({tag, ".rt"}, 32'(id_rt), 32'(e.instr[20:16]));
            check({tag, ".rd"}, 32'(id_rd), 32'(e.instr[15:11]));
            check({tag, ".shamt"}, 32'(id_shamt), 32'(e.instr[10:6]));
            check({tag, ".imm"}, 32'(id_imm16), 32'(e.instr[15:0]));
            check({tag, ".tgt"}, 32'(id_target), 32'(e.instr[25:0]));
        end
    endtask

    task automatic step(input string tag);
        predict();
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    task automatic idle_inputs();
        imem_ready  = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        halt_req    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 32'h2000_0000 | i;
        rom[0] = I_ADD;
        rom[1] = I_LW;
        rom[2] = I_SW;

        // Reset
        idle_inputs();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst.pc", pc_out, 32'h0000_3000);
        check("rst.valid", 32'(id_valid), 32'd0);
        check("rst.instr", id_instr, 32'h0);
        check("rst.halted", 32'(halted), 32'd0);
        check("rst.perf_fetch", perf_fetch, 32'h0);
        rst = 1'b0;

        // Streaming add, lw, sw
        step("s_add");
        check("s_add.pc", pc_out, 32'h0000_3004);
        check("s_add.instr", id_instr, I_ADD);
        check("s_add.op", 32'(id_op), 32'h0);
        check("s_add.funct", 32'(id_funct), 32'h20);
        step("s_lw");
        check("s_lw.instr", id_instr, I_LW);

        // Stall two cycles holding lw; imem_ready ignored
        stall = 1'b1;
        imem_ready = 1'b0;
        step("st1");
        step("st2");
        check("st2.pc", pc_out, 32'h0000_3008);
        check("st2.instr", id_instr, I_LW);
        stall = 1'b0;
        imem_ready = 1'b1;
        step("st_resume");
        check("st_resume.instr", id_instr, I_SW);
        check("st_resume.pc4", id_pc4, 32'h0000_300C);

        // Redirect wins over stall, low bits dropped
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_3041;
        step("rd");
        check("rd.pc", pc_out, 32'h0000_3040);
        check("rd.valid", 32'(id_valid), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("rd.perf_flush", perf_flush, 32'd1);
`endif
        idle_inputs();
        step("rd_next");
        check("rd_next.instr", id_instr, 32'h2000_0010);

        // Memory not ready for three cycles
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("nr");
        check("nr.pc", pc_out, 32'h0000_3044);
        check("nr.instr", id_instr, 32'h0);
        imem_ready = 1'b1;
        step("nr_resume");
        check("nr_resume.instr", id_instr, 32'h2000_0011);

        // PC wrap at top of address space
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step("wr_rd");
        redirect = 1'b0;
        step("wr");
        check("wr.pc", pc_out, 32'h0);
        check("wr.pc4", id_pc4, 32'h0);
        check("wr.instr", id_instr, 32'h2000_03FF);
        step("wr_next");
        check("wr_next.instr", id_instr, I_ADD);

        // Halt beats redirect; then everything ignored
        halt_req = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_5000;
        step("h");
        check("h.halted", 32'(halted), 32'd1);
        check("h.pc", pc_out, 32'h0000_0004);
        halt_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            stall    = 1'(i & 1);
            redirect = 1'((i >> 1) & 1);
            step("hold");
        end
        check("hold.pc", pc_out, 32'h0000_0004);

        // Async reset mid-stall
        rst = 1'b1;
        #2;
        model_reset();
        check("arst_h.pc", pc_out, 32'h0000_3000);
        check("arst_h.halted", 32'(halted), 32'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        rst = 1'b0;
        step("p1");
        step("p2");
        stall = 1'b1;
        step("p_st");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_s.pc", pc_out, 32'h0000_3000);
        check("arst_s.valid", 32'(id_valid), 32'd0);
        check("arst_s.instr", id_instr, 32'h0);
        @(posedge clk);
        #1;
        stall = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h0000_3100;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_r.pc", pc_out, 32'h0000_3000);
        @(posedge clk);
        #1;
        idle_inputs();
        rst = 1'b0;
        step("post");
        check("post.pc", pc_out, 32'h0000_3004);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
